// File: rtl/wvb_readout_arbiter.sv
// ---------------------------------------------------------------------------
// wvb_readout_arbiter
//
// Round-robin readout controller shared by P_N_CHAN waveform buffers. A channel
// with a pending header (and its enable set) is granted. Its header is presented
// first, then each sample is read and presented until the end-of-waveform (EOE)
// word. The waveform is then released with a one-cycle wvb_rddone pulse. All
// words leave on a single valid/ready stream.
//
// Optional feature (compile-time macro WVB_RDOUT_LEN_LIMIT_EN):
//   This macro adds a per-waveform sample counter. If the P_MAX_WORDS-th sample
//   has no EOE, it is presented with out_last forced high, sticky err_len is set,
//   and the waveform is released. Without the macro, readout ends only on EOE,
//   err_len is tied low and err_clr is ignored.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   chan_en       per-channel arbitration enable
//   hdr_empty     per-channel header FIFO empty
//   hdr_data      show-ahead headers, channel i at [i*P_HDR_WIDTH +: P_HDR_WIDTH]
//   hdr_rdreq     header pop strobe (combinational, on header handshake)
//   wvb_data      sample words, valid one cycle after wvb_rdreq
//   wvb_rdreq     sample read strobe
//   wvb_rddone    waveform release pulse
//   out_valid / out_ready / out_data / out_is_hdr / out_last / out_chan
//                 output stream; samples are zero-extended to P_HDR_WIDTH
//   busy          controller is not idle
//   err_len       sticky length-limit error
//   err_clr       clears err_len (a set in the same cycle wins)
// ---------------------------------------------------------------------------
module wvb_readout_arbiter #(
    parameter int P_N_CHAN     = 4,
    parameter int P_CHAN_WIDTH = 2,
    parameter int P_DATA_WIDTH = 22,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_MAX_WORDS  = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [P_N_CHAN-1:0]              chan_en,
    input  logic [P_N_CHAN-1:0]              hdr_empty,
    input  logic [P_N_CHAN*P_HDR_WIDTH-1:0]  hdr_data,
    output logic [P_N_CHAN-1:0]              hdr_rdreq,
    input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_data,
    output logic [P_N_CHAN-1:0]              wvb_rdreq,
    output logic [P_N_CHAN-1:0]              wvb_rddone,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [P_HDR_WIDTH-1:0]           out_data,
    output logic                             out_is_hdr,
    output logic                             out_last,
    output logic [P_CHAN_WIDTH-1:0]          out_chan,
    output logic                             busy,
    output logic                             err_len,
    input  logic                             err_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DREQ,
        S_DCAP,
        S_DOUT,
        S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [P_CHAN_WIDTH-1:0] chan;
    logic [P_CHAN_WIDTH-1:0] rr_ptr;
    logic [P_CHAN_WIDTH-1:0] grant;
    logic                    grant_vld;
    logic [P_N_CHAN-1:0]     req;
    logic [P_DATA_WIDTH-1:0] sample;
    logic                    sample_last;   // out_last value for the sample being captured
    logic                    handshake;

    assign req       = chan_en & ~hdr_empty;
    assign sample    = wvb_data[int'(chan)*P_DATA_WIDTH +: P_DATA_WIDTH];
    assign handshake = out_valid & out_ready;
    assign busy      = (state != S_IDLE);
    assign out_chan  = chan;

    // First requesting channel at or after rr_ptr, wrapping around.
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        for (int i = 0; i < P_N_CHAN; i++) begin
            if (!grant_vld && req[(int'(rr_ptr) + i) % P_N_CHAN]) begin
                grant_vld = 1'b1;
                grant     = P_CHAN_WIDTH'((int'(rr_ptr) + i) % P_N_CHAN);
            end
        end
    end

    // Next state and strobes. Strobes go only to the latched channel, and
    // each state drives at most one strobe type, so they never overlap.
    always_comb begin
        state_nxt  = state;
        out_valid  = 1'b0;
        hdr_rdreq  = '0;
        wvb_rdreq  = '0;
        wvb_rddone = '0;
        case (state)
            S_IDLE: if (grant_vld) state_nxt = S_HDR;
            S_HDR: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    hdr_rdreq[chan] = 1'b1;
                    state_nxt       = S_DREQ;
                end
            end
            S_DREQ: begin
                wvb_rdreq[chan] = 1'b1;
                state_nxt       = S_DCAP;
            end
            S_DCAP: state_nxt = S_DOUT;
            S_DOUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = out_last ? S_DONE : S_DREQ;
            end
            S_DONE: begin
                wvb_rddone[chan] = 1'b1;
                state_nxt        = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Output word registers only load in IDLE (grant) and DCAP (capture), so
    // they hold steady for as long as out_valid waits on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan       <= '0;
            rr_ptr     <= '0;
            out_data   <= '0;
            out_is_hdr <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        chan       <= grant;
                        out_data   <= hdr_data[int'(grant)*P_HDR_WIDTH +: P_HDR_WIDTH];
                        out_is_hdr <= 1'b1;
                        out_last   <= 1'b0;
                    end
                end
                S_DCAP: begin
                    out_data   <= {{(P_HDR_WIDTH-P_DATA_WIDTH){1'b0}}, sample};
                    out_is_hdr <= 1'b0;
                    out_last   <= sample_last;
                end
                S_DONE: rr_ptr <= (int'(chan) == P_N_CHAN - 1) ? '0 : chan + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef WVB_RDOUT_LEN_LIMIT_EN
    localparam int CNT_WIDTH = $clog2(P_MAX_WORDS + 1);

    logic [CNT_WIDTH-1:0] sample_cnt;   // samples already handed over in this waveform
    logic                 limit_hit;
    logic                 err_q;

    // The sample being captured is the (sample_cnt+1)-th one.
    assign limit_hit   = (sample_cnt == CNT_WIDTH'(P_MAX_WORDS - 1)) && !sample[P_DATA_WIDTH-1];
    assign sample_last = sample[P_DATA_WIDTH-1] | limit_hit;
    assign err_len     = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state == S_HDR)
                sample_cnt <= '0;
            else if (state == S_DOUT && handshake)
                sample_cnt <= sample_cnt + 1'b1;

            if (state == S_DCAP && limit_hit)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;
        end
    end
`else
    localparam int unused_max_words = P_MAX_WORDS;
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign sample_last    = sample[P_DATA_WIDTH-1];
    assign err_len        = 1'b0;
`endif

endmodule

// File: tb/tb_wvb_readout_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wvb_readout_arbiter
//
// Bench for wvb_readout_arbiter. A behavioural model of the four waveform
// buffers holds queues of headers and samples. It pops them on the DUT strobes
// and drives wvb_data only in the cycle after wvb_rdreq, with junk at all other
// times. A planner derives the expected output word sequence from the
// round-robin rule applied to the waveforms that are loaded.
// ---------------------------------------------------------------------------
module tb_wvb_readout_arbiter;

    localparam int N    = 4;
    localparam int CW   = 2;
    localparam int DW   = 22;
    localparam int HW   = 80;
    localparam int MAXW = 8;

    typedef struct packed {
        logic          is_hdr;
        logic          last;
        logic [CW-1:0] chan;
        logic [HW-1:0] data;
    } word_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    chan_en;
    logic [N-1:0]    hdr_empty;
    logic [N*HW-1:0] hdr_data;
    logic [N-1:0]    hdr_rdreq;
    logic [N*DW-1:0] wvb_data;
    logic [N-1:0]    wvb_rdreq;
    logic [N-1:0]    wvb_rddone;
    logic            out_valid;
    logic            out_ready;
    logic [HW-1:0]   out_data;
    logic            out_is_hdr;
    logic            out_last;
    logic [CW-1:0]   out_chan;
    logic            busy;
    logic            err_len;
    logic            err_clr;

    wvb_readout_arbiter #(
        .P_N_CHAN(N), .P_CHAN_WIDTH(CW), .P_DATA_WIDTH(DW),
        .P_HDR_WIDTH(HW), .P_MAX_WORDS(MAXW)
    ) dut (
        .clk(clk), .rst(rst), .chan_en(chan_en), .hdr_empty(hdr_empty),
        .hdr_data(hdr_data), .hdr_rdreq(hdr_rdreq), .wvb_data(wvb_data),
        .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_is_hdr(out_is_hdr),
        .out_last(out_last), .out_chan(out_chan), .busy(busy),
        .err_len(err_len), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Buffer model (what the DUT reads) and planner copies (what is expected).
    logic [HW-1:0] hdr_q[N][$];
    logic [DW-1:0] smp_q[N][$];
    bit            mid_wf[N];
    logic [HW-1:0] plan_hdr[N][$];
    logic [DW-1:0] plan_smp[N][$];
    word_t         exp_q[$];
    int            model_ptr;
    bit            exp_err;
    int            exp_hdr[N], exp_wvb[N], exp_done[N];
    int            n_hdr[N], n_wvb[N], n_done[N];

    int            ready_mode;     // 0: always ready, 1: random, 2: ready_manual
    logic          ready_manual;
    bit            stall_prev;
    word_t         stall_w;

    // Monitor at negedge, buffer update and input drive just after posedge.
    initial begin : bus_model
        logic [N-1:0]  h, w, d;
        word_t         cur, e;
        logic [DW-1:0] s;
        logic [HW-1:0] hd;
        forever begin
            @(negedge clk);
            h   = hdr_rdreq;
            w   = wvb_rdreq;
            d   = wvb_rddone;
            cur = {out_is_hdr, out_last, out_chan, out_data};
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (|(h | w | d)) begin
                    tests++;
                    if ($countones({h, w, d}) != 1 || (h | w | d) != (4'b0001 << out_chan)) begin
                        fails++;
                        $display("FAIL strobes: hdr=%b wvb=%b done=%b chan=%0d", h, w, d, out_chan);
                    end
                    for (int ch = 0; ch < N; ch++) begin
                        n_hdr[ch]  += int'(h[ch]);
                        n_wvb[ch]  += int'(w[ch]);
                        n_done[ch] += int'(d[ch]);
                    end
                end
                if (stall_prev) begin
                    tests++;
                    if (!out_valid || cur !== stall_w) begin
                        fails++;
                        $display("FAIL stall_hold: valid=%b got=%h want=%h", out_valid, cur, stall_w);
                    end
                end
                if (out_valid && out_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_word: got=%h", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            fails++;
                            $display("FAIL out_word: got=%h want=%h", cur, e);
                        end
                    end
                end
                stall_prev = out_valid && !out_ready;
                stall_w    = cur;
            end

            @(posedge clk);
            #1;
            for (int ch = 0; ch < N; ch++) begin
                wvb_data[ch*DW +: DW] = DW'($urandom);
                if (!rst) begin
                    if (h[ch] && hdr_q[ch].size() > 0) hd = hdr_q[ch].pop_front();
                    if (w[ch] && smp_q[ch].size() > 0) begin
                        s = smp_q[ch].pop_front();
                        mid_wf[ch] = !s[DW-1];
                        wvb_data[ch*DW +: DW] = s;
                    end
                    // A release drops whatever is left of a truncated waveform.
                    if (d[ch]) begin
                        while (mid_wf[ch] && smp_q[ch].size() > 0) begin
                            s = smp_q[ch].pop_front();
                            mid_wf[ch] = !s[DW-1];
                        end
                        mid_wf[ch] = 1'b0;
                    end
                end
                hdr_empty[ch] = (hdr_q[ch].size() == 0);
                hdr_data[ch*HW +: HW] = (hdr_q[ch].size() > 0) ? hdr_q[ch][0] : HW'($urandom);
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = ready_manual;
            endcase
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_model();
        for (int ch = 0; ch < N; ch++) begin
            hdr_q[ch].delete();
            smp_q[ch].delete();
            plan_hdr[ch].delete();
            plan_smp[ch].delete();
            mid_wf[ch]   = 1'b0;
            exp_hdr[ch]  = 0; exp_wvb[ch] = 0; exp_done[ch] = 0;
            n_hdr[ch]    = 0; n_wvb[ch]   = 0; n_done[ch]   = 0;
        end
        exp_q.delete();
        model_ptr  = 0;
        exp_err    = 1'b0;
        stall_prev = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // One waveform of n samples on channel ch; EOE on the last sample.
    task automatic load_wf(input int ch, input int n);
        logic [95:0]   r;
        logic [DW-1:0] s;
        r = {$urandom, $urandom, $urandom};
        hdr_q[ch].push_back(r[HW-1:0]);
        plan_hdr[ch].push_back(r[HW-1:0]);
        for (int k = 0; k < n; k++) begin
            s = DW'($urandom);
            s[DW-1] = (k == n - 1);
            smp_q[ch].push_back(s);
            plan_smp[ch].push_back(s);
        end
    endtask

    // Serve all loaded waveforms on enabled channels in round-robin order.
    task automatic plan(input logic [N-1:0] en);
        int            c, cnt;
        logic [DW-1:0] s, t;
        logic          last;
        word_t         wd;
        bit            more;
        more = 1'b1;
        while (more) begin
            c = -1;
            for (int i = 0; i < N; i++)
                if (c < 0 && en[(model_ptr + i) % N] && plan_hdr[(model_ptr + i) % N].size() > 0)
                    c = (model_ptr + i) % N;
            if (c < 0) begin
                more = 1'b0;
            end else begin
                wd.is_hdr = 1'b1; wd.last = 1'b0; wd.chan = CW'(c);
                wd.data   = plan_hdr[c].pop_front();
                exp_q.push_back(wd);
                exp_hdr[c]++;
                cnt  = 0;
                last = 1'b0;
                while (!last && plan_smp[c].size() > 0) begin
                    s    = plan_smp[c].pop_front();
                    cnt++;
                    last = s[DW-1];
                    exp_wvb[c]++;
`ifdef WVB_RDOUT_LEN_LIMIT_EN
                    if (cnt == MAXW && !last) begin
                        last    = 1'b1;
                        exp_err = 1'b1;
                        t = '0;
                        while (!t[DW-1] && plan_smp[c].size() > 0) t = plan_smp[c].pop_front();
                    end
`endif
                    wd.is_hdr = 1'b0; wd.last = last; wd.chan = CW'(c); wd.data = HW'(s);
                    exp_q.push_back(wd);
                end
                exp_done[c]++;
                model_ptr = (c + 1) % N;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= budget) begin
            fails++;
            $display("FAIL timeout: %0d words still expected, busy=%b", exp_q.size(), busy);
        end
    endtask

    task automatic wait_word(input bit want_hdr, input int budget);
        int k = 0;
        while (!(out_valid && out_is_hdr == want_hdr) && k < budget) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= budget) begin
            fails++;
            $display("FAIL wait_word: no word with is_hdr=%b within %0d cycles", want_hdr, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_model();
        #2;
        tests++;
        if ({out_valid, busy, hdr_rdreq, wvb_rdreq, wvb_rddone, out_data, out_is_hdr,
             out_last, out_chan, err_len} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_in_reset: valid=%b busy=%b data=%h", out_valid, busy, out_data);
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, busy, out_data, out_is_hdr, out_last, out_chan, err_len} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_after: valid=%b busy=%b data=%h", out_valid, busy, out_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        ready_mode = 0;
        chan_en    = 4'b1111;
        load_wf(2, 3);
        plan(chan_en);
        wait_done(200);
        for (int ch = 0; ch < N; ch++) begin
            tests++;
            if (n_hdr[ch] != exp_hdr[ch] || n_wvb[ch] != exp_wvb[ch] || n_done[ch] != exp_done[ch]) begin
                fails++;
                $display("FAIL single_counts ch%0d: hdr=%0d/%0d wvb=%0d/%0d done=%0d/%0d", ch,
                         n_hdr[ch], exp_hdr[ch], n_wvb[ch], exp_wvb[ch], n_done[ch], exp_done[ch]);
            end
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        clear_model();
        ready_mode = 1;
        chan_en    = 4'b1111;
        for (int r = 0; r < 2; r++)
            for (int ch = 0; ch < N; ch++) load_wf(ch, int'($urandom_range(1, 4)));
        plan(chan_en);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        wait_done(3000);
        for (int ch = 0; ch < N; ch++) begin
            tests++;
            if (n_done[ch] != 2 || n_wvb[ch] != exp_wvb[ch]) begin
                fails++;
                $display("FAIL rr_counts ch%0d: done=%0d want 2, wvb=%0d want %0d",
                         ch, n_done[ch], n_wvb[ch], exp_wvb[ch]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready_mode   = 2;
        ready_manual = 1'b0;
        chan_en      = 4'b1111;
        load_wf(1, 3);
        plan(chan_en);
        wait_word(1'b1, 50);
        repeat (10) @(negedge clk);
        @(posedge clk); #2 ready_manual = 1'b1;
        @(posedge clk); #2 ready_manual = 1'b0;
        wait_word(1'b0, 50);
        repeat (10) @(negedge clk);
        tests++;
        if (n_hdr[1] != 1 || n_wvb[1] != 1) begin
            fails++;
            $display("FAIL stall_strobes: hdr=%0d want 1, wvb=%0d want 1", n_hdr[1], n_wvb[1]);
        end
        ready_manual = 1'b1;
        wait_done(200);
        tests++;
        if (n_hdr[1] != 1 || n_wvb[1] != 3 || n_done[1] != 1) begin
            fails++;
            $display("FAIL bp_counts: hdr=%0d wvb=%0d done=%0d want 1/3/1", n_hdr[1], n_wvb[1], n_done[1]);
        end
    endtask

    task automatic test_chan_mask();
        int k = 0;
        do_reset();
        ready_mode = 1;
        chan_en    = 4'b1011;
        for (int ch = 0; ch < N; ch++) load_wf(ch, int'($urandom_range(2, 4)));
        plan(chan_en);
        while (!(out_valid && !out_is_hdr && out_chan == 2'd0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= 100) begin
            fails++;
            $display("FAIL mask_wait: channel 0 sample never presented");
        end
        @(posedge clk); #2 chan_en = 4'b1010;
        load_wf(0, 2);
        wait_done(2000);
        for (int ch = 0; ch < N; ch++) begin
            tests++;
            if (n_hdr[ch] != exp_hdr[ch] || n_done[ch] != exp_done[ch]) begin
                fails++;
                $display("FAIL mask_counts ch%0d: hdr=%0d/%0d done=%0d/%0d",
                         ch, n_hdr[ch], exp_hdr[ch], n_done[ch], exp_done[ch]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ready_mode = 0;
        chan_en    = 4'b1111;
        load_wf(2, 2);
        plan(chan_en);
        wait_done(200);
        ready_mode   = 2;
        ready_manual = 1'b0;
        load_wf(3, 4);
        plan(chan_en);
        wait_word(1'b1, 50);
        @(posedge clk); #2 ready_manual = 1'b1;
        @(posedge clk); #2 ready_manual = 1'b0;
        wait_word(1'b0, 50);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({out_valid, busy, hdr_rdreq, wvb_rdreq, wvb_rddone, out_data, out_is_hdr,
             out_last, out_chan, err_len} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: valid=%b busy=%b data=%h chan=%0d",
                     out_valid, busy, out_data, out_chan);
        end
        clear_model();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        ready_mode = 0;
        load_wf(3, 2);
        load_wf(0, 2);
        plan(chan_en);
        wait_done(200);
        tests++;
        if (n_done[0] != 1 || n_done[3] != 1 || n_done[2] != 0) begin
            fails++;
            $display("FAIL reset_mid_counts: done0=%0d done3=%0d done2=%0d want 1/1/0",
                     n_done[0], n_done[3], n_done[2]);
        end
    endtask

    task automatic test_long();
        do_reset();
        ready_mode = 1;
        chan_en    = 4'b1111;
        load_wf(1, 20);
        plan(chan_en);
        wait_done(3000);
        tests++;
        if (n_wvb[1] != exp_wvb[1] || n_done[1] != 1) begin
            fails++;
            $display("FAIL long_counts: wvb=%0d want %0d, done=%0d want 1", n_wvb[1], exp_wvb[1], n_done[1]);
        end
        tests++;
        if (err_len !== exp_err) begin
            fails++;
            $display("FAIL long_err_len: got=%b want=%b", err_len, exp_err);
        end
        @(posedge clk); #2 err_clr = 1'b1;
        @(posedge clk); #2 err_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (err_len !== 1'b0) begin
            fails++;
            $display("FAIL err_clr: got=%b want=0", err_len);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            do_reset();
            ready_mode = 1;
            chan_en    = 4'($urandom_range(1, 15));
            for (int ch = 0; ch < N; ch++)
                for (int r = int'($urandom_range(0, 2)); r > 0; r--)
                    load_wf(ch, int'($urandom_range(1, 5)));
            plan(chan_en);
            wait_done(4000);
            for (int ch = 0; ch < N; ch++) begin
                tests++;
                if (n_hdr[ch] != exp_hdr[ch] || n_wvb[ch] != exp_wvb[ch] || n_done[ch] != exp_done[ch]) begin
                    fails++;
                    $display("FAIL random_counts it%0d ch%0d: hdr=%0d/%0d wvb=%0d/%0d done=%0d/%0d", it, ch,
                             n_hdr[ch], exp_hdr[ch], n_wvb[ch], exp_wvb[ch], n_done[ch], exp_done[ch]);
                end
            end
        end
    endtask

    initial begin : main
        rst          = 1'b1;
        chan_en      = '0;
        err_clr      = 1'b0;
        out_ready    = 1'b0;
        ready_mode   = 0;
        ready_manual = 1'b0;
        hdr_empty    = '1;
        hdr_data     = '0;
        wvb_data     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_chan_mask();
        test_reset_mid();
        test_long();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
